flop_bank_arbiter: RTL

Round-robin write arbiter and sequencer for a shared bank of D-type data registers. Up to `N_REQ` requesters compete for write access to a `2**AW`-entry, `DW`-bit register bank. The block grants one writer at a time with fair rotation, commits the captured word into the bank, and provides one registered read port. It sits between the control-path requesters and the flip-flop storage, so the storage never sees more than one write per commit.

---
 rtl/flop_bank_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/flop_bank_arbiter.sv
// Round-robin write arbiter and sequencer for a shared flop-based register bank.
// One grant per two cycles; the captured word is committed in the WRITE cycle.
module flop_bank_arbiter #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*AW-1:0] wr_addr,
    input  logic [N_REQ*DW-1:0] wr_data,
    input  logic                clr,
    input  logic [AW-1:0]       rd_addr,
    output logic [N_REQ-1:0]    gnt,
    output logic                busy,
    output logic [DW-1:0]       rd_data
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [AW-1:0]       cap_addr_q, cap_addr_d;
    logic [DW-1:0]       cap_data_q, cap_data_d;
    logic [DW-1:0]       bank_q [DEPTH];
    logic [DW-1:0]       bank_d [DEPTH];
    logic [DW-1:0]       rd_data_q, rd_data_d;

    logic                win_found;
    logic [PW-1:0]       win_idx;
    logic [PW-1:0]       cand;

    // Rotating priority search starting at ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            cand = PW'((int'(ptr_q) + k) % int'(N_REQ));
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state, capture, bank update and read port.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = '0;
        cap_addr_d = cap_addr_q;
        cap_data_d = cap_data_q;
        bank_d     = bank_q;
        rd_data_d  = bank_q[rd_addr];

        if (clr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                bank_d[i] = '0;
            end
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        cap_addr_d = wr_addr[int'(win_idx)*int'(AW) +: AW];
                        cap_data_d = wr_data[int'(win_idx)*int'(DW) +: DW];
                        gnt_d      = N_REQ'(1) << win_idx;
                        ptr_d      = (int'(win_idx) == int'(N_REQ) - 1) ? '0
                                                                        : PW'(int'(win_idx) + 1);
                        state_d    = S_WRITE;
                    end
                end
                S_WRITE: begin
                    bank_d[cap_addr_q] = cap_data_q;
                    state_d            = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            cap_addr_q <= '0;
            cap_data_q <= '0;
            rd_data_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            cap_addr_q <= cap_addr_d;
            cap_data_q <= cap_data_d;
            rd_data_q  <= rd_data_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q == S_WRITE);
    assign rd_data = rd_data_q;

endmodule
